// File: rtl/tokenizer_pkg.sv
// Shared definitions for the line tokenizer: FSM state codes, default
// character constants and a delimiter helper for 8-bit character sets.
package tokenizer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] DEF_EOL = 8'h0A;
  localparam logic [7:0] DEF_WC  = 8'h20;
  localparam logic [7:0] DEF_WC2 = 8'h09;

  function automatic logic is_delim(input logic [7:0] ch, input logic [7:0] wc,
                                    input logic [7:0] wc2);
    return (ch == wc) || (ch == wc2);
  endfunction

endpackage

// File: rtl/tok_char_classify.sv
// Combinational classification of the character under the scan index and the
// one after it: delimiter, and terminator (end of valid length or EOL).
module tok_char_classify
  import tokenizer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW = 6,
  parameter logic [WIDTH-1:0] EOL = WIDTH'(DEF_EOL),
  parameter logic [WIDTH-1:0] WC  = WIDTH'(DEF_WC),
  parameter logic [WIDTH-1:0] WC2 = WIDTH'(DEF_WC2)
) (
  input  logic [WIDTH-1:0] cur_ch,
  input  logic [WIDTH-1:0] nxt_ch,
  input  logic [IW-1:0]    idx,
  input  logic [IW-1:0]    nxt_idx,
  input  logic [IW-1:0]    len,
  output logic             cur_delim,
  output logic             cur_term,
  output logic             nxt_delim,
  output logic             nxt_term
);

  assign cur_delim = (cur_ch == WC) || (cur_ch == WC2);
  assign nxt_delim = (nxt_ch == WC) || (nxt_ch == WC2);
  assign cur_term  = (idx >= len) || (cur_ch == EOL);
  assign nxt_term  = (nxt_idx >= len) || (nxt_ch == EOL);

endmodule

// File: rtl/word_tokenizer.sv
// Buffers one line and streams its token characters over valid/ready with
// start/end-of-token flags, token length and overflow, closing with an EOL beat.
module word_tokenizer
  import tokenizer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENGTH = 32,
  parameter int MAX_TOKEN = 16,
  parameter logic [WIDTH-1:0] EOL = WIDTH'(DEF_EOL),
  parameter logic [WIDTH-1:0] WC  = WIDTH'(DEF_WC),
  parameter logic [WIDTH-1:0] WC2 = WIDTH'(DEF_WC2)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic [LENGTH*WIDTH-1:0]        i_line,
  input  logic [$clog2(LENGTH+1)-1:0]    i_len,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_sot,
  output logic                           o_eot,
  output logic                           o_eol,
  output logic [$clog2(MAX_TOKEN+1)-1:0] o_tok_len,
  output logic                           o_tok_ovf
);

  localparam int IW  = $clog2(LENGTH + 1);
  localparam int AW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int TLW = $clog2(MAX_TOKEN + 1);
  localparam logic [IW-1:0] LEN_L = IW'(LENGTH);
  localparam logic [IW-1:0] MAX_L = IW'(MAX_TOKEN);

  logic [1:0]              state;
  logic [LENGTH*WIDTH-1:0] line_q;
  logic [IW-1:0]           len_q;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           nxt_idx;
  logic [IW-1:0]           tok_cnt;
  logic [IW-1:0]           cnt_new;
  logic [IW-1:0]           len_in;
  logic [TLW-1:0]          len_sat;
  logic [AW-1:0]           cur_sel;
  logic [AW-1:0]           nxt_sel;
  logic [WIDTH-1:0]        cur_ch;
  logic [WIDTH-1:0]        nxt_ch;
  logic                    cur_delim;
  logic                    cur_term;
  logic                    nxt_delim;
  logic                    nxt_term;
  logic                    take;

  // Reads past the buffer return 0; the length compare marks them terminators.
  always_comb begin
    nxt_idx = idx + IW'(1);
    cur_sel = idx[AW-1:0];
    nxt_sel = nxt_idx[AW-1:0];
    cur_ch  = '0;
    nxt_ch  = '0;
    if (idx < LEN_L) cur_ch = line_q[cur_sel*WIDTH +: WIDTH];
    if (nxt_idx < LEN_L) nxt_ch = line_q[nxt_sel*WIDTH +: WIDTH];
  end

  tok_char_classify #(
    .WIDTH(WIDTH),
    .IW(IW),
    .EOL(EOL),
    .WC(WC),
    .WC2(WC2)
  ) u_classify (
    .cur_ch(cur_ch),
    .nxt_ch(nxt_ch),
    .idx(idx),
    .nxt_idx(nxt_idx),
    .len(len_q),
    .cur_delim(cur_delim),
    .cur_term(cur_term),
    .nxt_delim(nxt_delim),
    .nxt_term(nxt_term)
  );

  always_comb begin
    len_in  = (i_len > LEN_L) ? LEN_L : i_len;
    cnt_new = (state == ST_SCAN) ? IW'(1) : tok_cnt + IW'(1);
    len_sat = (cnt_new > MAX_L) ? TLW'(MAX_TOKEN) : TLW'(cnt_new);
    take    = !cur_term && !cur_delim;
  end

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_EMIT) || (state == ST_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      line_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      tok_cnt   <= '0;
      o_data    <= '0;
      o_sot     <= 1'b0;
      o_eot     <= 1'b0;
      o_eol     <= 1'b0;
      o_tok_len <= '0;
      o_tok_ovf <= 1'b0;
    end else if (i_en) begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            line_q    <= i_line;
            len_q     <= len_in;
            idx       <= '0;
            tok_cnt   <= '0;
            o_tok_ovf <= 1'b0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur_term) begin
            o_data    <= EOL;
            o_eol     <= 1'b1;
            o_sot     <= 1'b0;
            o_eot     <= 1'b0;
            o_tok_len <= '0;
            state     <= ST_DONE;
          end else if (cur_delim) begin
            idx <= nxt_idx;
          end else begin
            o_data    <= cur_ch;
            o_sot     <= 1'b1;
            o_eot     <= nxt_term || nxt_delim;
            o_tok_len <= len_sat;
            tok_cnt   <= cnt_new;
            idx       <= nxt_idx;
            if (cnt_new > MAX_L) o_tok_ovf <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // Continue the token without a bubble when the next char belongs to it.
          if (i_ready) begin
            if (take) begin
              o_data    <= cur_ch;
              o_sot     <= 1'b0;
              o_eot     <= nxt_term || nxt_delim;
              o_tok_len <= len_sat;
              tok_cnt   <= cnt_new;
              idx       <= nxt_idx;
              if (cnt_new > MAX_L) o_tok_ovf <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        default: begin
          if (i_ready) begin
            o_eol  <= 1'b0;
            o_data <= '0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_tokenizer.sv
// Directed bench for word_tokenizer: collects handshaken beats per line and
// compares them against hand-written expected beat lists.
module tb_word_tokenizer;

  localparam int LENGTH = 32;
  localparam int WIDTH = 8;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n = 1'b1;
  logic                    i_en = 1'b1;
  logic [LENGTH*WIDTH-1:0] i_line = '0;
  logic [5:0]              i_len = '0;
  logic                    i_valid = 1'b0;
  logic                    o_ready;
  logic [7:0]              o_data;
  logic                    o_valid;
  logic                    i_ready = 1'b0;
  logic                    o_sot;
  logic                    o_eot;
  logic                    o_eol;
  logic [4:0]              o_tok_len;
  logic                    o_tok_ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] beats[$];
  logic [16:0] expq[$];

  word_tokenizer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_line(i_line),
    .i_len(i_len), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_sot(o_sot), .o_eot(o_eot),
    .o_eol(o_eol), .o_tok_len(o_tok_len), .o_tok_ovf(o_tok_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LENGTH*WIDTH-1:0] build_line(input string s);
    logic [LENGTH*WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < s.len() && k < LENGTH; k++) v[k*8 +: 8] = s[k];
    return v;
  endfunction

  // Beat record: {ovf, eol, eot, sot, len (only meaningful with eot), data}
  function automatic logic [16:0] bt(input logic [7:0] ch, input bit sot, input bit eot,
                                     input int len, input bit ovf);
    logic [4:0] l;
    l = len[4:0];
    return {ovf, 1'b0, eot, sot, l, ch};
  endfunction

  function automatic logic [16:0] eol_bt(input bit ovf);
    return {ovf, 1'b1, 1'b0, 1'b0, 5'd0, 8'h0A};
  endfunction

  function automatic logic [16:0] obs_bt();
    return {o_tok_ovf, o_eol, o_eot, o_sot, (o_eot ? o_tok_len : 5'd0), o_data};
  endfunction

  task automatic run_line(input string s, input int n, input bit stall);
    int cyc;
    bit done;
    bit stalled;
    logic [16:0] snap;
    beats.delete();
    i_line = build_line(s);
    i_len = n[5:0];
    i_en = 1'b1;
    i_ready = 1'b0;
    i_valid = 1'b1;
    cyc = 0;
    while (!o_ready && cyc < 50) begin
      @(posedge i_clk); #1; cyc++;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    done = 1'b0;
    stalled = 1'b0;
    snap = '0;
    cyc = 0;
    while (!done && cyc < 500) begin
      if (stalled) check("stall_hold", {15'd0, o_valid, obs_bt()}, {15'd0, 1'b1, snap});
      if (stall) begin
        i_en = ($urandom_range(3) != 0);
        i_ready = ($urandom_range(1) == 1);
      end else begin
        i_en = 1'b1;
        i_ready = 1'b1;
      end
      stalled = o_valid && !(i_en && i_ready);
      snap = obs_bt();
      if (o_valid && i_en && i_ready) begin
        beats.push_back(obs_bt());
        if (o_eol) done = 1'b1;
      end
      @(posedge i_clk); #1; cyc++;
    end
    if (!done) check("eol_timeout", 0, 1);
    i_ready = 1'b0;
    i_en = 1'b1;
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, beats.size(), expq.size());
    for (int i = 0; i < beats.size() && i < expq.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), beats[i], expq[i]);
    check({tag, "_ready_after"}, o_ready, 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, o_ready, 1);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_flags"}, {o_sot, o_eot, o_eol, o_tok_ovf}, 0);
    check({tag, "_toklen"}, o_tok_len, 0);
  endtask

  initial begin
    #2 i_rst_n = 1'b0;
    #1 check_cleared("reset");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // i_en low: an offered line must not be taken
    i_en = 1'b0;
    i_line = build_line("zz");
    i_len = 6'd2;
    i_valid = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("en_freeze_ready", o_ready, 1);
    check("en_freeze_valid", o_valid, 0);
    i_valid = 1'b0;
    i_en = 1'b1;

    run_line("ab  cd\n", 7, 1'b0);
    expq = {bt("a", 1, 0, 0, 0), bt("b", 0, 1, 2, 0), bt("c", 1, 0, 0, 0),
            bt("d", 0, 1, 2, 0), eol_bt(0)};
    compare_beats("abcd");

    run_line("   x", 4, 1'b0);
    expq = {bt("x", 1, 1, 1, 0), eol_bt(0)};
    compare_beats("lead_delim");

    run_line("", 0, 1'b0);
    expq = {eol_bt(0)};
    compare_beats("empty");

    run_line("    ", 4, 1'b0);
    expq = {eol_bt(0)};
    compare_beats("all_delim");

    run_line("\t \t", 3, 1'b0);
    expq = {eol_bt(0)};
    compare_beats("tab_delim");

    run_line("zzzzzzzzzzzzzzzzzzzz", 20, 1'b0);
    expq.delete();
    for (int i = 1; i <= 20; i++)
      expq.push_back(bt("z", i == 1, i == 20, (i == 20) ? 16 : 0, i >= 17));
    expq.push_back(eol_bt(1));
    compare_beats("long_tok");

    run_line("q", 1, 1'b0);
    expq = {bt("q", 1, 1, 1, 0), eol_bt(0)};
    compare_beats("ovf_clear");

    run_line("ab\ncd", 5, 1'b0);
    expq = {bt("a", 1, 0, 0, 0), bt("b", 0, 1, 2, 0), eol_bt(0)};
    compare_beats("after_eol");

    run_line("dup swap", 8, 1'b0);
    expq = {bt("d", 1, 0, 0, 0), bt("u", 0, 0, 0, 0), bt("p", 0, 1, 3, 0),
            bt("s", 1, 0, 0, 0), bt("w", 0, 0, 0, 0), bt("a", 0, 0, 0, 0),
            bt("p", 0, 1, 4, 0), eol_bt(0)};
    compare_beats("dup_nostall");
    run_line("dup swap", 8, 1'b1);
    compare_beats("dup_stall");

    // Asynchronous reset in the middle of a token
    i_line = build_line("hello world");
    i_len = 6'd11;
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("midtok_valid_before", o_valid, 1);
    #3 i_rst_n = 1'b0;
    #1 check_cleared("midreset");
    @(negedge i_clk) i_rst_n = 1'b1;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    run_line("ok", 2, 1'b0);
    expq = {bt("o", 1, 0, 0, 0), bt("k", 0, 1, 2, 0), eol_bt(0)};
    compare_beats("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/word_tokenizer.md
Name: word_tokenizer

Overview:
Next-generation tokenizer between the terminal line buffer and the parser. It accepts a whole line and streams only token characters over a valid/ready handshake, marking token start and token end. Runs of delimiters are collapsed, and every line is closed with an end-of-line beat. Width, line depth, maximum token length and the delimiter set are parameters; token length and overflow are reported to the parser.

Parameters:
WIDTH, 8, character width in bits
LENGTH, 32, maximum line length in characters
MAX_TOKEN, 16, longest legal token; longer tokens raise o_tok_ovf
EOL, "\n", end-of-line character; terminates the line early
WC, " ", primary delimiter
WC2, "\t", secondary delimiter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_en  in  1  clock enable; low freezes all state and outputs
i_line  in  LENGTH*WIDTH  line characters, char k at bits [k*WIDTH +: WIDTH]
i_len  in  $clog2(LENGTH+1)  number of valid characters
i_valid  in  1  line offered
o_ready  out  1  block can accept a line (IDLE)
o_data  out  WIDTH  token character, or EOL on the closing beat
o_valid  out  1  o_data and flags valid
i_ready  in  1  parser accepts the current beat
o_sot  out  1  first character of a token
o_eot  out  1  last character of a token
o_eol  out  1  closing end-of-line beat
o_tok_len  out  $clog2(MAX_TOKEN+1)  token length; valid with o_eot, saturates at MAX_TOKEN
o_tok_ovf  out  1  current line contained a token longer than MAX_TOKEN; sticky until next line is accepted

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE; o_ready=1; o_data=0; o_valid, o_sot, o_eot, o_eol, o_tok_len, o_tok_ovf all 0; internal line buffer, index and counters cleared. Reset mid-line discards the line with no EOL beat.
- i_en=0: no register changes. Handshakes are not counted.
- Delimiter: character equal to WC or WC2. Terminator: index == min(i_len, LENGTH), or a character equal to EOL. Characters after EOL are ignored.
- IDLE: o_ready=1. When i_valid=1, register i_line, register the clamped length (i_len > LENGTH clamps to LENGTH), set index=0, clear o_tok_ovf, and go to SCAN.
- SCAN: o_valid=0 and o_ready=0. Evaluate one character per cycle:
  - Delimiter: increment index.
  - Non-delimiter: load it into the output register with o_sot=1, increment index, go to EMIT.
  - Terminator: load the EOL beat (o_data=EOL, o_eol=1, o_sot=o_eot=0), go to DONE.
- EMIT: o_valid=1. Outputs hold stable while i_ready=0. When o_valid&i_ready:
  - Next character is a non-delimiter: load it in the same cycle with o_sot=0. This gives back-to-back beats within a token.
  - Otherwise: drop o_valid and go to SCAN.
- o_eot: set at load time when the following character is a delimiter or terminator (lookahead into the registered buffer). A single-character token has o_sot=o_eot=1.
- o_tok_len: running count per token. It saturates at MAX_TOKEN. When a token reaches MAX_TOKEN+1 characters, set o_tok_ovf=1; characters keep streaming.
- DONE: o_valid=1, o_eol=1. On i_ready, go to IDLE. A line is accepted in the cycle after the EOL beat is consumed, never in the same cycle.
- Latency: line accepted at edge N. If char 0 is a non-delimiter, o_valid rises after edge N+1. Each skipped delimiter adds one cycle.
- Empty or all-delimiter line (including i_len=0): only the EOL beat is emitted.

Decomposition:
- Package tokenizer_pkg: state enum (IDLE, SCAN, EMIT, DONE), is_delim function over WC/WC2, default EOL/WC/WC2 constants.
- Optional sub-module tok_char_classify: combinational classification of the current and next character (delim, eol, terminator), shared with the future parser front-end.

Test Plan:
- "ab  cd\n", i_len=7, i_ready=1 constantly -> beats a(sot), b(eot, len 2), c(sot), d(eot, len 2), EOL(eol). One idle cycle per skipped delimiter; no beats after EOL.
- "   x", i_len=4 -> single beat x with sot=eot=1 and len 1, then the EOL beat. o_ready returns high after the EOL beat.
- i_len=0 and then "    " -> each line emits only EOL (o_data=EOL, o_eol=1), with o_sot=o_eot=0.
- Token of 20 'z' chars, LENGTH=32, MAX_TOKEN=16 -> 20 beats; o_tok_ovf rises on the 17th beat; eot beat carries len 16 (saturated); ovf clears on the next accept.
- Random i_ready backpressure and i_en toggling on "dup swap" -> o_data and flags stable while stalled; beat sequence identical to the no-stall run.
- i_rst_n pulsed low mid-token (asynchronously, between edges) -> outputs clear immediately; o_ready=1; the next line is tokenized from index 0.
